// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg                                                            |
// | Shared character constants, FSM states and width helper for the      |
// | trace line arbiter.                                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam logic [7:0] CH_START  = 8'h5E;  // '^'
  localparam logic [7:0] CH_END    = 8'h23;  // '#'
  localparam logic [7:0] CH_RESYNC = 8'h0A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  function automatic int sw_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_picker                                                            |
// | Combinational round-robin pick: first request after i_ptr, wrapping. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_picker #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_idx
);

  logic          w_found;
  logic [SW-1:0] w_cand_idx;

  always_comb begin
    o_gnt      = '0;
    o_idx      = '0;
    w_found    = 1'b0;
    w_cand_idx = '0;
    // The pointer itself is visited last, so the previous winner has lowest priority.
    for (int k = 1; k <= N; k++) begin
      w_cand_idx = SW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_cand_idx]) begin
        w_found           = 1'b1;
        o_gnt[w_cand_idx] = 1'b1;
        o_idx             = w_cand_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_line_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_line_arbiter                                                   |
// | Grants whole '^'..'#' trace lines from N sources round-robin onto    |
// | one registered character stream; aborts stalled/overlong lines.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module trace_line_arbiter
  import trace_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int TIMEOUT = 16,
  parameter int MAX_LEN = 48,
  localparam int SW     = sw_width(N_SRC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     in_valid,
  input  logic [8*N_SRC-1:0]   in_char,
  output logic [N_SRC-1:0]     in_ready,
  output logic                 out_valid,
  output logic [7:0]           out_char,
  output logic [SW-1:0]        out_src,
  output logic                 out_abort,
  output logic [15:0]          line_cnt,
  output logic [7:0]           abort_cnt
);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_rr_ptr, r_grant;
  logic [7:0]    r_len, r_idle_cnt;
  logic          r_out_valid, r_out_abort;
  logic [7:0]    r_out_char;
  logic [SW-1:0] r_out_src;
  logic [15:0]   r_line_cnt;
  logic [7:0]    r_abort_cnt;

  logic [7:0]       w_chars [N_SRC];
  logic [N_SRC-1:0] w_is_start, w_cand, w_pick_gnt;
  logic [SW-1:0]    w_pick_idx;
  logic [7:0]       w_gchar;
  logic             w_gvalid;
  logic             w_take_start, w_fwd, w_line_done, w_idle_tick;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign w_chars[i]    = in_char[8*i +: 8];
    assign w_is_start[i] = (w_chars[i] == CH_START);
  end

  assign w_cand   = in_valid & w_is_start;
  assign w_gchar  = w_chars[r_grant];
  assign w_gvalid = in_valid[r_grant];

  rr_picker #(.N(N_SRC), .SW(SW)) u_pick (
    .i_req (w_cand),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = ~w_is_start;  // non-granted sources: flush data, hold '^'
    w_take_start = 1'b0;
    w_fwd        = 1'b0;
    w_line_done  = 1'b0;
    w_idle_tick  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = ~w_is_start | w_pick_gnt;
        if (|w_cand) begin
          w_take_start = 1'b1;
          w_state_nxt  = BUSY;
        end
      end
      BUSY: begin
        in_ready[r_grant] = 1'b1;
        // A closing '#' beats both abort conditions in the same cycle.
        if (w_gvalid && (w_gchar == CH_END)) begin
          w_fwd       = 1'b1;
          w_line_done = 1'b1;
          w_state_nxt = IDLE;
        end else if ((r_idle_cnt == 8'(TIMEOUT)) ||
                     (w_gvalid && (r_len == 8'(MAX_LEN - 1)))) begin
          w_state_nxt = ABORT;
        end else if (w_gvalid) begin
          w_fwd = 1'b1;
        end else begin
          w_idle_tick = 1'b1;
        end
      end
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= SW'(N_SRC - 1);
      r_grant     <= '0;
      r_len       <= '0;
      r_idle_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_abort <= 1'b0;
      r_out_char  <= '0;
      r_out_src   <= '0;
      r_line_cnt  <= '0;
      r_abort_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      r_out_abort <= 1'b0;
      if (w_take_start) begin
        r_grant     <= w_pick_idx;
        r_rr_ptr    <= w_pick_idx;
        r_len       <= 8'd1;
        r_idle_cnt  <= '0;
        r_out_valid <= 1'b1;
        r_out_char  <= CH_START;
        r_out_src   <= w_pick_idx;
      end
      if (w_fwd) begin
        r_len       <= r_len + 8'd1;
        r_idle_cnt  <= '0;
        r_out_valid <= 1'b1;
        r_out_char  <= w_gchar;
        r_out_src   <= r_grant;
      end
      if (w_idle_tick) r_idle_cnt <= r_idle_cnt + 8'd1;
      if (w_line_done) r_line_cnt <= r_line_cnt + 16'd1;
      if (r_state == ABORT) begin
        r_out_valid <= 1'b1;
        r_out_abort <= 1'b1;
        r_out_char  <= CH_RESYNC;
        r_out_src   <= r_grant;
        if (r_abort_cnt != 8'hFF) r_abort_cnt <= r_abort_cnt + 8'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_src   = r_out_src;
  assign out_abort = r_out_abort;
  assign line_cnt  = r_line_cnt;
  assign abort_cnt = r_abort_cnt;

endmodule
`default_nettype wire
